// File: rtl/trap_sequencer.sv
// Trap entry / mret sequencer: owns the CSR port during a trap and issues the PC redirect.
// Define TRAP_MTVAL_EN to include the mtval write on trap entry.
module trap_sequencer #(
   parameter int XLEN    = 64,
   parameter int CSR_LAT = 1,
   parameter int CODE_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic [1:0]        i_kind,
   input  logic [CODE_W-1:0] i_code,
   input  logic [XLEN-1:0]   i_pc,
   input  logic [XLEN-1:0]   i_tval,
   output logic              o_busy,
   output logic              req,
   input  logic              ack,
   output logic              o_pc_jmp,
   output logic [XLEN-1:0]   o_pc_jmpaddr,
   output logic [11:0]       o_csr_addr,
   output logic              o_csr_ren,
   output logic              o_csr_wen,
   output logic [XLEN-1:0]   o_csr_wdata,
   input  logic [XLEN-1:0]   i_csr_rdata
);

   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;
`ifdef TRAP_MTVAL_EN
   localparam logic [11:0] A_MTVAL   = 12'h343;
`endif

   localparam logic [1:0] K_IRQ  = 2'd1;
   localparam logic [1:0] K_MRET = 2'd2;
   localparam logic [1:0] K_RSVD = 2'd3;
   localparam logic [1:0] LAT    = 2'(CSR_LAT);

   typedef enum logic [3:0] {
      IDLE,
      W_MEPC,
      W_MCAUSE,
`ifdef TRAP_MTVAL_EN
      W_MTVAL,
`endif
      R_MTVEC,
      R_MSTATUS,
      R_MEPC,
      W_MSTATUS,
      DONE
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [1:0]        cnt_q;
   logic [1:0]        cnt_d;
   logic [1:0]        kind_q;
   logic [CODE_W-1:0] code_q;
   logic [XLEN-1:1]   pc_q;
   logic [XLEN-1:2]   tvec_q;
   logic [1:0]        tmode_q;
   logic [XLEN-1:0]   mstatus_q;
   logic [XLEN-1:1]   mepc_q;
`ifdef TRAP_MTVAL_EN
   logic [XLEN-1:0]   tval_q;
   logic              unused_ok;
   assign unused_ok = ^{i_pc[0], i_csr_rdata[0]};
`else
   logic              unused_ok;
   assign unused_ok = ^{i_pc[0], i_csr_rdata[0], i_tval};
`endif

   logic              strobe;
   logic              phase_end;
   logic              accept;
   logic              is_irq;
   logic [XLEN-1:0]   mcause;
   logic [XLEN-1:0]   ms_entry;
   logic [XLEN-1:0]   ms_mret;
   logic [XLEN-1:0]   vec_off;
   logic [XLEN-1:0]   target;

   // cnt_q counts through one access phase: strobe at 0, done at LAT
   assign strobe    = cnt_q == 2'd0;
   assign phase_end = cnt_q == LAT;
   assign accept    = state_q == IDLE && ena && i_kind != K_RSVD;
   assign is_irq    = kind_q == K_IRQ;
   assign o_busy    = state_q != IDLE;
   assign o_pc_jmp  = req;

   always_comb begin
      mcause             = '0;
      mcause[XLEN-1]     = is_irq;
      mcause[CODE_W-1:0] = code_q;
      ms_entry           = mstatus_q;
      ms_entry[12:11]    = 2'b11;
      ms_entry[7]        = mstatus_q[3];
      ms_entry[3]        = 1'b0;
      ms_mret            = mstatus_q;
      ms_mret[12:11]     = 2'b00;
      ms_mret[7]         = 1'b1;
      ms_mret[3]         = mstatus_q[7];
      vec_off            = '0;
      if (is_irq && tmode_q == 2'b01)
         vec_off[CODE_W+1:2] = code_q;
      if (kind_q == K_MRET)
         target = {mepc_q, 1'b0};
      else
         target = {tvec_q, 2'b00} + vec_off;
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = '0;
      o_csr_addr   = '0;
      o_csr_ren    = 1'b0;
      o_csr_wen    = 1'b0;
      o_csr_wdata  = '0;
      req          = 1'b0;
      o_pc_jmpaddr = '0;
      unique case (state_q)
         IDLE: begin
            if (accept)
               state_d = (i_kind == K_MRET) ? R_MSTATUS : W_MEPC;
         end
         W_MEPC: begin
            o_csr_addr  = A_MEPC;
            o_csr_wen   = strobe;
            o_csr_wdata = {pc_q, 1'b0};
            if (phase_end)
               state_d = W_MCAUSE;
         end
         W_MCAUSE: begin
            o_csr_addr  = A_MCAUSE;
            o_csr_wen   = strobe;
            o_csr_wdata = mcause;
            if (phase_end)
`ifdef TRAP_MTVAL_EN
               state_d = W_MTVAL;
`else
               state_d = R_MTVEC;
`endif
         end
`ifdef TRAP_MTVAL_EN
         W_MTVAL: begin
            o_csr_addr  = A_MTVAL;
            o_csr_wen   = strobe;
            o_csr_wdata = is_irq ? '0 : tval_q;
            if (phase_end)
               state_d = R_MTVEC;
         end
`endif
         R_MTVEC: begin
            o_csr_addr = A_MTVEC;
            o_csr_ren  = strobe;
            if (phase_end)
               state_d = R_MSTATUS;
         end
         R_MSTATUS: begin
            o_csr_addr = A_MSTATUS;
            o_csr_ren  = strobe;
            if (phase_end)
               state_d = (kind_q == K_MRET) ? R_MEPC : W_MSTATUS;
         end
         R_MEPC: begin
            o_csr_addr = A_MEPC;
            o_csr_ren  = strobe;
            if (phase_end)
               state_d = W_MSTATUS;
         end
         W_MSTATUS: begin
            o_csr_addr  = A_MSTATUS;
            o_csr_wen   = strobe;
            o_csr_wdata = (kind_q == K_MRET) ? ms_mret : ms_entry;
            if (phase_end)
               state_d = DONE;
         end
         DONE: begin
            req          = 1'b1;
            o_pc_jmpaddr = target;
            if (ack)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (!o_csr_wen)
         o_csr_wdata = '0;
      if (state_q != IDLE && state_q != DONE && !phase_end)
         cnt_d = cnt_q + 2'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         kind_q    <= '0;
         code_q    <= '0;
         pc_q      <= '0;
         tvec_q    <= '0;
         tmode_q   <= '0;
         mstatus_q <= '0;
         mepc_q    <= '0;
`ifdef TRAP_MTVAL_EN
         tval_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            kind_q <= i_kind;
            code_q <= i_code;
            pc_q   <= i_pc[XLEN-1:1];
`ifdef TRAP_MTVAL_EN
            tval_q <= i_tval;
`endif
         end
         // read data is only valid in the last cycle of a phase
         if (phase_end) begin
            if (state_q == R_MTVEC)
               {tvec_q, tmode_q} <= i_csr_rdata;
            if (state_q == R_MSTATUS)
               mstatus_q <= i_csr_rdata;
            if (state_q == R_MEPC)
               mepc_q <= i_csr_rdata[XLEN-1:1];
         end
      end
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// Randomized bench for trap_sequencer: a CSR-file model plus an access-list
// reference for entry, vectored interrupts, mret, ack stalls and reset abort.
module tb_trap_sequencer;

   localparam int LAT = 1;
`ifdef TRAP_MTVAL_EN
   localparam bit MTV = 1'b1;
`else
   localparam bit MTV = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        ena;
   logic [1:0]  i_kind;
   logic [5:0]  i_code;
   logic [63:0] i_pc;
   logic [63:0] i_tval;
   logic        o_busy;
   logic        req;
   logic        ack;
   logic        o_pc_jmp;
   logic [63:0] o_pc_jmpaddr;
   logic [11:0] o_csr_addr;
   logic        o_csr_ren;
   logic        o_csr_wen;
   logic [63:0] o_csr_wdata;
   logic [63:0] i_csr_rdata;

   logic [63:0] m_mtvec;
   logic [63:0] m_mstatus;
   logic [63:0] m_mepc;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int          cyc;
      logic [11:0] addr;
      logic        w;
      logic [63:0] d;
   } acc_t;

   acc_t exp_q[$];
   acc_t obs_q[$];

   always #5 clk = ~clk;

   assign i_csr_rdata = (o_csr_addr == 12'h305) ? m_mtvec :
                        (o_csr_addr == 12'h300) ? m_mstatus :
                        (o_csr_addr == 12'h341) ? m_mepc : 64'h0;

   trap_sequencer #(.XLEN(64), .CSR_LAT(LAT), .CODE_W(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .ena          (ena),
      .i_kind       (i_kind),
      .i_code       (i_code),
      .i_pc         (i_pc),
      .i_tval       (i_tval),
      .o_busy       (o_busy),
      .req          (req),
      .ack          (ack),
      .o_pc_jmp     (o_pc_jmp),
      .o_pc_jmpaddr (o_pc_jmpaddr),
      .o_csr_addr   (o_csr_addr),
      .o_csr_ren    (o_csr_ren),
      .o_csr_wen    (o_csr_wen),
      .o_csr_wdata  (o_csr_wdata),
      .i_csr_rdata  (i_csr_rdata)
   );

   function automatic void add(logic [11:0] a, logic w, logic [63:0] d);
      acc_t e;
      e.cyc  = 1 + exp_q.size() * (1 + LAT);
      e.addr = a;
      e.w    = w;
      e.d    = d;
      exp_q.push_back(e);
   endfunction

   // Must be called at a negedge with the DUT idle; returns at a negedge.
   task automatic run_seq(input string nm, input logic [1:0] kind,
                          input logic [5:0] code, input logic [63:0] pc,
                          input logic [63:0] tval, input int hold,
                          input bit ena_busy, input bit ena_ack);
      logic [63:0] ms;
      logic [63:0] ms_new;
      logic [63:0] tgt;
      logic [63:0] tgt_seen;
      logic [11:0] last_addr;
      logic        irq;
      int          n;
      int          held;
      int          req_cyc;
      int          bad_hold;
      int          bad_both;
      int          bad_addr;
      int          tval_cyc;
      int          exp_tval_cyc;
      bit          done;
      acc_t        o;
      exp_q.delete();
      obs_q.delete();
      ms  = m_mstatus;
      irq = kind == 2'd1;
      if (kind == 2'd2) begin
         add(12'h300, 1'b0, 64'h0);
         add(12'h341, 1'b0, 64'h0);
         ms_new = (ms & ~64'h1888) | 64'h80 | (ms[7] ? 64'h8 : 64'h0);
         add(12'h300, 1'b1, ms_new);
         tgt = m_mepc & ~64'h1;
      end else begin
         add(12'h341, 1'b1, pc & ~64'h1);
         add(12'h342, 1'b1, (64'(irq) << 63) | 64'(code));
         if (MTV)
            add(12'h343, 1'b1, irq ? 64'h0 : tval);
         add(12'h305, 1'b0, 64'h0);
         add(12'h300, 1'b0, 64'h0);
         ms_new = (ms & ~64'h88) | 64'h1800 | (ms[3] ? 64'h80 : 64'h0);
         add(12'h300, 1'b1, ms_new);
         tgt = (m_mtvec & ~64'h3) +
               ((irq && m_mtvec[1:0] == 2'b01) ? 64'(code) * 64'd4 : 64'h0);
      end
      exp_tval_cyc = (MTV && kind != 2'd2) ? 1 + LAT : 0;
      ena = 1'b1;
      i_kind = kind;
      i_code = code;
      i_pc = pc;
      i_tval = tval;
      ack = 1'b0;
      n = 0; held = 0; req_cyc = -1; done = 0;
      bad_hold = 0; bad_both = 0; bad_addr = 0; tval_cyc = 0;
      tgt_seen = '0;
      last_addr = '0;
      while (!done && n < 80) begin
         @(negedge clk);
         n++;
         if (o_csr_ren && o_csr_wen)
            bad_both++;
         if (o_csr_addr == 12'h343)
            tval_cyc++;
         if (o_csr_ren || o_csr_wen) begin
            o.cyc = n; o.addr = o_csr_addr; o.w = o_csr_wen; o.d = o_csr_wdata;
            obs_q.push_back(o);
            last_addr = o_csr_addr;
         end else if (o_busy && !req && o_csr_addr !== last_addr)
            bad_addr++;
         ena = ena_busy ? 1'($urandom_range(0, 1)) : 1'b0;
         i_kind = 2'($urandom_range(0, 2));
         i_code = 6'($urandom);
         i_pc = {$urandom, $urandom};
         i_tval = {$urandom, $urandom};
         if (req) begin
            if (req_cyc < 0) begin
               req_cyc = n;
               tgt_seen = o_pc_jmpaddr;
            end else if (o_pc_jmpaddr !== tgt_seen || o_pc_jmp !== 1'b1)
               bad_hold++;
            if (held == hold) begin
               ack = 1'b1;
               ena = ena_ack;
               i_kind = 2'd0;
               done = 1;
            end else begin
               ack = 1'b0;
               held++;
            end
         end else
            ack = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      tests++;
      if ({req, o_pc_jmp, o_busy, o_csr_ren, o_csr_wen} !== 5'b0 ||
          o_pc_jmpaddr !== 64'h0) begin
         fails++;
         $display("FAIL %s post_ack: req=%b jmp=%b busy=%b ren=%b wen=%b addr=%h, required all 0",
                  nm, req, o_pc_jmp, o_busy, o_csr_ren, o_csr_wen, o_pc_jmpaddr);
      end
      ack = 1'b0;
      ena = 1'b0;
      tests++;
      if (obs_q.size() != exp_q.size()) begin
         fails++;
         $display("FAIL %s access_count: got %0d required %0d",
                  nm, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         tests++;
         if (i >= obs_q.size()) begin
            fails++;
            $display("FAIL %s access%0d: missing, required addr %h w=%b cyc %0d",
                     nm, i, exp_q[i].addr, exp_q[i].w, exp_q[i].cyc);
         end else if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].w !== exp_q[i].w ||
                      obs_q[i].cyc != exp_q[i].cyc ||
                      (exp_q[i].w && obs_q[i].d !== exp_q[i].d)) begin
            fails++;
            $display("FAIL %s access%0d: got addr %h w=%b d=%h cyc %0d, required addr %h w=%b d=%h cyc %0d",
                     nm, i, obs_q[i].addr, obs_q[i].w, obs_q[i].d, obs_q[i].cyc,
                     exp_q[i].addr, exp_q[i].w, exp_q[i].d, exp_q[i].cyc);
         end
      end
      tests++;
      if (req_cyc != exp_q.size() * (1 + LAT) + 1) begin
         fails++;
         $display("FAIL %s req_cycle: got %0d required %0d (-1 = never)",
                  nm, req_cyc, exp_q.size() * (1 + LAT) + 1);
      end
      tests++;
      if (tgt_seen !== tgt) begin
         fails++;
         $display("FAIL %s jmpaddr: got %h required %h", nm, tgt_seen, tgt);
      end
      tests++;
      if (bad_hold != 0 || bad_both != 0 || bad_addr != 0) begin
         fails++;
         $display("FAIL %s stability: hold_err=%0d both_strobe=%0d addr_drift=%0d, required 0",
                  nm, bad_hold, bad_both, bad_addr);
      end
      tests++;
      if (tval_cyc != exp_tval_cyc) begin
         fails++;
         $display("FAIL %s mtval_addr_cycles: got %0d required %0d",
                  nm, tval_cyc, exp_tval_cyc);
      end
      foreach (exp_q[i]) begin
         if (exp_q[i].w && exp_q[i].addr == 12'h300) m_mstatus = exp_q[i].d;
         if (exp_q[i].w && exp_q[i].addr == 12'h341) m_mepc = exp_q[i].d;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; ena = 1'b0; ack = 1'b0;
      i_kind = '0; i_code = '0; i_pc = '0; i_tval = '0;
      m_mtvec = '0; m_mstatus = '0; m_mepc = '0;
      repeat (2) @(negedge clk);
      tests++;
      if ({o_busy, req, o_pc_jmp, o_csr_ren, o_csr_wen} !== 5'b0 ||
          o_pc_jmpaddr !== 64'h0 || o_csr_addr !== 12'h0 || o_csr_wdata !== 64'h0) begin
         fails++;
         $display("FAIL reset: busy=%b req=%b addr=%h wdata=%h, required all 0",
                  o_busy, req, o_csr_addr, o_csr_wdata);
      end
      rst = 1'b0;
   endtask

   task automatic test_exception();
      m_mtvec = 64'h8000_0100;
      m_mstatus = 64'h8;
      run_seq("exc11", 2'd0, 6'd11, 64'h8000_0040, 64'hDEAD_BEEF_0000_1234, 0, 0, 0);
   endtask

   task automatic test_vectored_irq();
      m_mtvec = 64'h8000_0101;
      m_mstatus = 64'h8;
      run_seq("irq7_vec", 2'd1, 6'd7, 64'h8000_0200, 64'h55, 1, 0, 0);
      run_seq("exc2_vec", 2'd0, 6'd2, 64'h8000_0301, 64'h77, 0, 0, 0);
   endtask

   task automatic test_mret();
      m_mstatus = 64'h1880;
      m_mepc = 64'h8000_0045;
      run_seq("mret", 2'd2, 6'd0, 64'h0, 64'h0, 0, 0, 0);
   endtask

   task automatic test_ack_hold();
      m_mtvec = 64'h8000_0100;
      run_seq("ack_hold", 2'd0, 6'd3, 64'h8000_1000, 64'h99, 5, 1, 1);
   endtask

   task automatic test_reset_abort();
      int n;
      ena = 1'b1; i_kind = 2'd0; i_code = 6'd5;
      i_pc = 64'h8000_2000; i_tval = 64'h1;
      n = 0;
      do begin
         @(negedge clk);
         ena = 1'b0;
         n++;
      end while (o_csr_addr !== 12'h305 && n < 40);
      tests++;
      if (o_csr_addr !== 12'h305) begin
         fails++;
         $display("FAIL abort_reach_mtvec: addr %h required 305", o_csr_addr);
      end
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if ({o_busy, req, o_pc_jmp, o_csr_ren, o_csr_wen} !== 5'b0 ||
          o_csr_addr !== 12'h0 || o_pc_jmpaddr !== 64'h0) begin
         fails++;
         $display("FAIL abort_reset: busy=%b ren=%b wen=%b addr=%h, required all 0",
                  o_busy, o_csr_ren, o_csr_wen, o_csr_addr);
      end
      rst = 1'b0;
      run_seq("after_abort", 2'd0, 6'd5, 64'h8000_2000, 64'h1, 0, 0, 0);
   endtask

   task automatic test_reserved_kind();
      ena = 1'b1; i_kind = 2'd3;
      @(negedge clk);
      ena = 1'b0;
      repeat (2) begin
         tests++;
         if (o_busy !== 1'b0 || o_csr_ren !== 1'b0 || o_csr_wen !== 1'b0) begin
            fails++;
            $display("FAIL reserved_kind: busy=%b ren=%b wen=%b, required 0",
                     o_busy, o_csr_ren, o_csr_wen);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         m_mtvec = {$urandom, $urandom};
         m_mstatus = {$urandom, $urandom};
         m_mepc = {$urandom, $urandom};
         run_seq($sformatf("rand%0d", i), 2'($urandom_range(0, 2)), 6'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_exception();
      test_vectored_irq();
      test_mret();
      test_ack_hold();
      test_reset_abort();
      test_reserved_kind();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Parametrised trap entry/return sequencer for the M-mode core; generalises the single-path ecall/timer exception unit.
- Sits between the commit stage and the CSR file. Owns the CSR port during a trap.
- Handles synchronous exceptions with any cause code, interrupts with any cause code, and mret.
- Adds vectored mtvec, optional mtval write, and a configurable CSR access latency. Redirects the PC through a req/ack handshake.

Parameters:
- XLEN, 64, datapath width for pc, CSR data and cause.
- CSR_LAT, 1, wait cycles after each CSR strobe before the access completes; legal range 0..3.
- CODE_W, 6, width of the cause code field.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ena  in  1  start pulse; sampled only in IDLE
- i_kind  in  2  0=exception, 1=interrupt, 2=mret, 3=reserved (ignored)
- i_code  in  CODE_W  cause code
- i_pc  in  XLEN  pc of the trapping instruction
- i_tval  in  XLEN  trap value
- o_busy  out  1  high whenever state != IDLE
- req  out  1  redirect valid
- ack  in  1  consumer accepts redirect
- o_pc_jmp  out  1  redirect flag; equal to req
- o_pc_jmpaddr  out  XLEN  redirect target
- o_csr_addr  out  12  CSR address
- o_csr_ren  out  1  read strobe
- o_csr_wen  out  1  write strobe
- o_csr_wdata  out  XLEN  write data
- i_csr_rdata  in  XLEN  read data

Behaviour:
- Reset: all outputs 0 at the next clk edge and state=IDLE; latched kind/code/pc/tval and saved read data cleared.
- Reset mid-sequence aborts the sequence with no further strobes. A CSR write already strobed is not undone.
- Accept: in IDLE with ena=1 and i_kind!=3, latch i_kind, i_code, i_pc, i_tval and leave IDLE. Inputs are don't-care afterwards.
- ena while busy is ignored and not queued.
- Access phase (used by every CSR state): 1 strobe cycle (addr, ren/wen, wdata valid), then CSR_LAT idle cycles with strobes 0 and addr held. i_csr_rdata is sampled in the last cycle of the phase.
- Exactly one strobe per phase; ren and wen never both high.
- CSR addresses: MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343.
- Entry path (exception or interrupt): W_MEPC -> W_MCAUSE -> [W_MTVAL] -> R_MTVEC -> R_MSTATUS -> W_MSTATUS -> DONE.
  - W_MEPC writes {pc[XLEN-1:1],1'b0}.
  - W_MCAUSE writes bit XLEN-1 = (kind==1), code in the low CODE_W bits, all other bits 0.
  - W_MSTATUS writes the read value with MPP[12:11]=2'b11, MPIE[7]=old MIE[3], MIE[3]=0; all other bits unchanged.
- Target on entry:
  - If mtvec[1:0]==2'b01 and kind==1: {mtvec[XLEN-1:2],2'b00} + 4*code.
  - Otherwise (any exception, or mtvec modes 0, 2, 3): {mtvec[XLEN-1:2],2'b00}.
  - Addition wraps modulo 2^XLEN.
- mret path: R_MSTATUS -> R_MEPC -> W_MSTATUS -> DONE.
  - W_MSTATUS writes MIE=old MPIE, MPIE=1, MPP=2'b00; all other bits unchanged.
  - Target = {mepc[XLEN-1:1],1'b0}.
- Latency: with accept in cycle 0, req rises in cycle K*(1+CSR_LAT)+1.
  - K=6 for entry with mtval, 5 for entry without mtval, 3 for mret.
- DONE: req=o_pc_jmp=1 and o_pc_jmpaddr stable until a cycle with req&ack. In the next cycle req=o_pc_jmp=0, o_pc_jmpaddr=0, state=IDLE.
- ena in the ack cycle is ignored; ena in the following cycle is accepted.
- ack while req=0 has no effect.

Optional Feature:
- TRAP_MTVAL_EN defined: the W_MTVAL state exists and writes the latched i_tval for exceptions, or 0 for interrupts. mret never writes mtval.
- TRAP_MTVAL_EN undefined: the W_MTVAL state is removed, K is reduced by 1 on entry, address 0x343 is never driven, and i_tval is unused.

Test Plan:
- CSR_LAT=1, MTVAL_EN on; mtvec=0x8000_0100, mstatus=0x8; exception code 11 at pc 0x8000_0040:
  - Writes: mepc=0x8000_0040, mcause=11, mtval=i_tval, mstatus=0x1880.
  - req rises in cycle 13 with jmpaddr 0x8000_0100.
- mtvec=0x8000_0101; interrupt code 7:
  - mcause=0x8000_0000_0000_0007, jmpaddr=0x8000_011C.
  - Same mtvec with an exception code 2 gives jmpaddr 0x8000_0100.
- mret with mstatus=0x1880, mepc=0x8000_0045:
  - mstatus written 0x88, jmpaddr 0x8000_0044, req in cycle 7.
- Hold ack=0 for 5 cycles in DONE:
  - req and jmpaddr stay stable, no strobes.
  - A second ena pulse while busy is ignored; req drops the cycle after ack.
- Assert rst during R_MTVEC:
  - Next cycle all outputs 0 and state IDLE.
  - A following ena starts a clean sequence from W_MEPC.
- CSR_LAT=3 with MTVAL_EN off:
  - Each strobe is followed by 3 idle cycles; address 0x343 is never driven; req rises in cycle 21.
